// File: rtl/tx_uart.sv
// tx_uart: 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// The host queues bytes through a valid/ready handshake. While the FIFO
// holds bytes, frames go out back-to-back with no idle gap between them.
module tx_uart #(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // FIFO storage. The memory has no reset; after a reset the pointers
   // and the count make any stale contents unreachable.
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;

   // Transmit state
   logic [1:0]        state_reg, state_next;
   logic [BAUD_W-1:0] baud_reg, baud_next;
   logic [2:0]        bit_idx_reg, bit_idx_next;
   logic [7:0]        shift_reg, shift_next;
   logic              tx_reg, tx_next;

   logic push;
   logic pop;
   logic baud_last;

   // tx_ready looks only at the registered count, so a pop in the same
   // cycle never opens a slot for a push into a full FIFO.
   assign tx_ready  = (count_reg < DEPTH_C);
   assign push      = tx_valid & tx_ready;
   assign baud_last = (baud_reg == BAUD_LAST);

   assign tx      = tx_reg;
   assign tx_busy = (state_reg != S_IDLE);
   assign tx_done = (state_reg == S_STOP) && baud_last;

   // Store the offered byte at the write pointer when it is accepted
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= tx_data;
      end
   end

   // Pointer and occupancy bookkeeping. The pointers wrap naturally
   // because the depth is a power of two.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Frame sequencer. It pops the head byte when it leaves IDLE and again
   // on the last clock of a stop bit, so queued frames run back-to-back.
   always_comb begin
      state_next   = state_reg;
      baud_next    = baud_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      tx_next      = tx_reg;
      pop          = 1'b0;
      case (state_reg)
         S_IDLE: begin
            baud_next = '0;
            tx_next   = 1'b1;
            if (count_reg != '0) begin
               pop        = 1'b1;
               shift_next = fifo_mem[rd_ptr_reg];
               state_next = S_START;
               tx_next    = 1'b0;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_next    = '0;
               bit_idx_next = 3'd0;
               state_next   = S_DATA;
               tx_next      = shift_reg[0];
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  state_next = S_STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  shift_next   = {1'b0, shift_reg[7:1]};
                  tx_next      = shift_reg[1];
               end
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_next = '0;
               if (count_reg != '0) begin
                  pop        = 1'b1;
                  shift_next = fifo_mem[rd_ptr_reg];
                  state_next = S_START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = S_IDLE;
                  tx_next    = 1'b1;
               end
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
            baud_next  = '0;
            tx_next    = 1'b1;
         end
      endcase
   end

   // Register all state. A reset abandons any frame in flight and drops
   // every queued byte.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         state_reg   <= S_IDLE;
         baud_reg    <= '0;
         bit_idx_reg <= 3'd0;
         shift_reg   <= 8'h00;
         tx_reg      <= 1'b1;
      end else begin
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         count_reg   <= count_next;
         state_reg   <= state_next;
         baud_reg    <= baud_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
      end
   end

endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: checks tx_uart cycle by cycle against a frame-position model.
// It also decodes the serial line independently and compares each frame
// with the bytes the host had queued.
module tb_tx_uart;

   localparam int C     = 8;        // 80 Hz clock / 10 baud
   localparam int D     = 4;
   localparam int FRAME = 10 * C;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   tx_uart #(
      .CLK_FREQ  (80),
      .BAUD      (10),
      .FIFO_DEPTH(D)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queued bytes, plus the position inside the current frame
   logic [7:0] mq[$];
   logic [7:0] sent[$];
   int         pos = -1;
   logic [7:0] cur = 8'h00;
   bit         accepted = 1'b0;

   // Independent line decoder state
   int         dec_cnt = -1;
   logic [7:0] dec_byte = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_tx();
      int b;
      if (pos < 0) return 1'b1;
      b = pos / C;
      if (b == 0) return 1'b0;
      if (b <= 8) return cur[b-1];
      return 1'b1;
   endfunction

   // One clock: drive the inputs, advance the model, and compare after the edge
   task automatic tick(input logic r, input logic v, input logic [7:0] d);
      rst      = r;
      tx_valid = v;
      tx_data  = d;
      accepted = r && v && (mq.size() < D);
      @(posedge clk);
      #1;
      if (!r) begin
         mq.delete();
         sent.delete();
         pos     = -1;
         dec_cnt = -1;
      end else begin
         if (mq.size() > 0 && (pos < 0 || pos == FRAME - 1)) begin
            cur = mq.pop_front();
            pos = 0;
         end else if (pos == FRAME - 1) begin
            pos = -1;
         end else if (pos >= 0) begin
            pos++;
         end
         if (accepted) begin
            mq.push_back(d);
            sent.push_back(d);
            $display("push %02h at %0t", d, $time);
         end
      end
      check("tx",    32'(tx),       32'(exp_tx()));
      check("busy",  32'(tx_busy),  32'(pos >= 0));
      check("done",  32'(tx_done),  32'(pos == FRAME - 1));
      check("ready", 32'(tx_ready), 32'(mq.size() < D));
      if (r) begin
         if (dec_cnt < 0) begin
            if (tx == 1'b0) dec_cnt = 0;
         end else begin
            dec_cnt++;
            if (dec_cnt % C == C / 2 && dec_cnt / C >= 1 && dec_cnt / C <= 8) begin
               dec_byte[dec_cnt / C - 1] = tx;
            end
            if (dec_cnt == 9 * C + C / 2) begin
               check("stop_bit", 32'(tx), 32'd1);
               if (sent.size() == 0) begin
                  check("frame_unexpected", 32'(dec_byte), 32'hFFFF_FFFF);
               end else begin
                  check("frame", 32'(dec_byte), 32'(sent.pop_front()));
               end
               $display("frame %02h at %0t", dec_byte, $time);
               dec_cnt = -1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] lb [4];
      lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'hA5; lb[3] = 8'h5A;

      // Reset
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
      idle(2);

      // Single byte
      tick(1'b1, 1'b1, 8'hA5);
      idle(FRAME + 5);

      // Back-to-back pair
      tick(1'b1, 1'b1, 8'hA5);
      tick(1'b1, 1'b1, 8'h5A);
      idle(2 * FRAME + 5);

      // FIFO full: hold valid, advance the byte only on acceptance
      b = 8'h01;
      for (int i = 0; i < 800 && b <= 8'h06; i++) begin
         tick(1'b1, 1'b1, b);
         if (accepted) b = b + 8'h01;
         if (i == 9) check("accepted_first_10", 32'(b - 8'h01), 32'd5);
      end
      check("all_six_accepted", 32'(b), 32'h07);
      idle(6 * FRAME + 5);

      // Ignored push while full
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 8'h30 + 8'(i));
      tick(1'b1, 1'b1, 8'hFF);
      check("ff_rejected", 32'(accepted), 32'd0);
      idle(5 * FRAME + 5);

      // Reset during data bit 3, with two more bytes queued
      tick(1'b1, 1'b1, 8'hA5);
      tick(1'b1, 1'b1, 8'h11);
      tick(1'b1, 1'b1, 8'h22);
      for (int i = 0; i < 200 && pos != 4 * C + 2; i++) idle(1);
      check("reached_bit3", 32'(pos), 32'(4 * C + 2));
      tick(1'b0, 1'b0, 8'h00);
      idle(3 * FRAME);

      // Loopback-style sequence
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, lb[i]);
      idle(4 * FRAME + 5);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         tick(1'b1, ($urandom_range(0, 99) < 35), 8'($urandom));
      end
      idle(6 * FRAME + 10);
      check("frames_left", 32'(sent.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
